// File: rtl/mips_pkg.sv
// Shared ISA constants, select encodings and instruction field helpers
// for the P5 decode/execute slice.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BEQ  = 2'b01;
  localparam logic [1:0] NPC_J    = 2'b10;
  localparam logic [1:0] NPC_JR   = 2'b11;

  localparam logic [1:0] FWD_ID_GRF     = 2'd0;
  localparam logic [1:0] FWD_ID_ALU_MEM = 2'd1;
  localparam logic [1:0] FWD_ID_PC8_MEM = 2'd2;
  localparam logic [1:0] FWD_ID_PC8_EX  = 2'd3;

  localparam logic [1:0] FWD_EX_PIPE    = 2'd0;
  localparam logic [1:0] FWD_EX_WD_WB   = 2'd1;
  localparam logic [1:0] FWD_EX_PC8_MEM = 2'd2;
  localparam logic [1:0] FWD_EX_ALU_MEM = 2'd3;

  localparam logic [1:0] FWD_MEM_PIPE   = 2'd0;
  localparam logic [1:0] FWD_MEM_WD_WB  = 2'd1;

  typedef enum logic [2:0] {
    ALU_NONE,
    ALU_ADDU,
    ALU_SUBU,
    ALU_ORI,
    ALU_LUI,
    ALU_ADDI
  } alu_op_e;

  function automatic logic [5:0] f_op(input logic [31:0] i);
    return i[31:26];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] i);
    return i[5:0];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] i);
    return i[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] i);
    return i[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] i);
    return i[15:11];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] i);
    return i[15:0];
  endfunction

  function automatic logic is_addu(input logic [31:0] i);
    return f_op(i) == OP_RTYPE && f_funct(i) == FN_ADDU;
  endfunction

  function automatic logic is_subu(input logic [31:0] i);
    return f_op(i) == OP_RTYPE && f_funct(i) == FN_SUBU;
  endfunction

  function automatic logic is_jr(input logic [31:0] i);
    return f_op(i) == OP_RTYPE && f_funct(i) == FN_JR;
  endfunction

  function automatic logic is_jal(input logic [31:0] i);
    return f_op(i) == OP_JAL;
  endfunction

  function automatic logic is_sw(input logic [31:0] i);
    return f_op(i) == OP_SW;
  endfunction

  // Producers whose MEM-stage value is the ALU result (lw is excluded on purpose).
  function automatic logic is_alu_wr(input logic [31:0] i);
    return is_addu(i) || is_subu(i) || f_op(i) == OP_ORI || f_op(i) == OP_LUI;
  endfunction

  function automatic logic [4:0] dest_reg(input logic [31:0] i);
    if (is_addu(i) || is_subu(i)) return f_rd(i);
    if (f_op(i) == OP_ORI || f_op(i) == OP_LUI || f_op(i) == OP_LW) return f_rt(i);
    if (is_jal(i)) return 5'd31;
    return 5'd0;
  endfunction

  function automatic alu_op_e alu_op(input logic [31:0] i);
    if (is_addu(i)) return ALU_ADDU;
    if (is_subu(i)) return ALU_SUBU;
    case (f_op(i))
      OP_ORI:        return ALU_ORI;
      OP_LUI:        return ALU_LUI;
      OP_LW, OP_SW:  return ALU_ADDI;
      default:       return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/grf.sv
// 32x32 general register file: $0 reads as zero, combinational reads with
// write-through of the same-cycle WB write, async clear on reset.
module grf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wr_en;

  assign wr_en = we && (wa != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass is applied even while reset holds the array cleared.
  always_comb begin
    rd1 = (wr_en && ra1 == wa) ? wd : regs_q[ra1];
    rd2 = (wr_en && ra2 == wa) ? wd : regs_q[ra2];
  end

endmodule

// File: rtl/decode_execute_core.sv
// P5 MIPS decode / GRF / branch resolution / forwarding control / EX ALU.
// Define CORE_TRACE_EN to print a line for every committed GRF write.
module decode_execute_core
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_id,
  input  logic [31:0] pc_id,
  input  logic [31:0] instr_ex,
  input  logic [31:0] instr_mem,
  input  logic [31:0] instr_wb,
  input  logic [31:0] rs_data_ex,
  input  logic [31:0] rt_data_ex,
  input  logic [31:0] imm_ext_ex,
  input  logic [4:0]  rega3_mem,
  input  logic [4:0]  rega3_wb,
  input  logic [31:0] alu_out_mem,
  input  logic [31:0] pc8_ex,
  input  logic [31:0] pc8_mem,
  input  logic [31:0] wd_wb,
  input  logic        rf_we_wb,
  input  logic [31:0] pc_wb,
  output logic [1:0]  npc_op,
  output logic [31:0] npc_value,
  output logic [31:0] rs_data_id,
  output logic [31:0] rt_data_id,
  output logic [31:0] imm_ext_id,
  output logic [31:0] alu_a_ex,
  output logic [31:0] alu_b_ex,
  output logic [31:0] alu_out_ex,
  output logic [4:0]  rega3_ex,
  output logic [1:0]  fwd_rt_mem
);

  logic [1:0]  fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt;
  logic [31:0] id_rs_val, id_rt_val, pc4_id, br_off;
  logic        wb_write;

  assign wb_write = rf_we_wb && (rega3_wb != 5'd0);

  grf u_grf (
    .clk   (clk),
    .reset (reset),
    .ra1   (f_rs(instr_id)),
    .ra2   (f_rt(instr_id)),
    .we    (rf_we_wb),
    .wa    (rega3_wb),
    .wd    (wd_wb),
    .rd1   (rs_data_id),
    .rd2   (rt_data_id)
  );

  function automatic logic [1:0] id_sel(input logic [4:0] r);
    if (r == 5'd0) return FWD_ID_GRF;
    if (is_jal(instr_ex) && r == 5'd31) return FWD_ID_PC8_EX;
    if (r == rega3_mem && is_alu_wr(instr_mem)) return FWD_ID_ALU_MEM;
    if (r == rega3_mem && is_jal(instr_mem)) return FWD_ID_PC8_MEM;
    return FWD_ID_GRF;
  endfunction

  function automatic logic [1:0] ex_sel(input logic [4:0] r);
    if (r == 5'd0) return FWD_EX_PIPE;
    if (r == rega3_mem && is_alu_wr(instr_mem)) return FWD_EX_ALU_MEM;
    if (r == rega3_mem && is_jal(instr_mem)) return FWD_EX_PC8_MEM;
    if (wb_write && r == rega3_wb) return FWD_EX_WD_WB;
    return FWD_EX_PIPE;
  endfunction

  always_comb begin
    fwd_id_rs = id_sel(f_rs(instr_id));
    fwd_id_rt = id_sel(f_rt(instr_id));
    fwd_ex_rs = ex_sel(f_rs(instr_ex));
    fwd_ex_rt = ex_sel(f_rt(instr_ex));
  end

  always_comb begin
    case (fwd_id_rs)
      FWD_ID_ALU_MEM: id_rs_val = alu_out_mem;
      FWD_ID_PC8_MEM: id_rs_val = pc8_mem;
      FWD_ID_PC8_EX:  id_rs_val = pc8_ex;
      default:        id_rs_val = rs_data_id;
    endcase
    case (fwd_id_rt)
      FWD_ID_ALU_MEM: id_rt_val = alu_out_mem;
      FWD_ID_PC8_MEM: id_rt_val = pc8_mem;
      FWD_ID_PC8_EX:  id_rt_val = pc8_ex;
      default:        id_rt_val = rt_data_id;
    endcase
  end

  always_comb begin
    imm_ext_id = (f_op(instr_id) == OP_ORI) ? {16'd0, f_imm(instr_id)}
                                            : {{16{instr_id[15]}}, f_imm(instr_id)};
    pc4_id    = pc_id + 32'd4;
    br_off    = {{14{instr_id[15]}}, f_imm(instr_id), 2'b00};
    npc_op    = NPC_SEQ;
    npc_value = pc4_id;
    if (f_op(instr_id) == OP_BEQ && id_rs_val == id_rt_val) begin
      npc_op    = NPC_BEQ;
      npc_value = pc4_id + br_off;
    end else if (f_op(instr_id) == OP_J || f_op(instr_id) == OP_JAL) begin
      npc_op    = NPC_J;
      npc_value = {pc_id[31:28], instr_id[25:0], 2'b00};
    end else if (is_jr(instr_id)) begin
      npc_op    = NPC_JR;
      npc_value = id_rs_val;
    end
  end

  always_comb begin
    case (fwd_ex_rs)
      FWD_EX_WD_WB:   alu_a_ex = wd_wb;
      FWD_EX_PC8_MEM: alu_a_ex = pc8_mem;
      FWD_EX_ALU_MEM: alu_a_ex = alu_out_mem;
      default:        alu_a_ex = rs_data_ex;
    endcase
    case (fwd_ex_rt)
      FWD_EX_WD_WB:   alu_b_ex = wd_wb;
      FWD_EX_PC8_MEM: alu_b_ex = pc8_mem;
      FWD_EX_ALU_MEM: alu_b_ex = alu_out_mem;
      default:        alu_b_ex = rt_data_ex;
    endcase
  end

  always_comb begin
    case (alu_op(instr_ex))
      ALU_ADDU: alu_out_ex = alu_a_ex + alu_b_ex;
      ALU_SUBU: alu_out_ex = alu_a_ex - alu_b_ex;
      ALU_ORI:  alu_out_ex = alu_a_ex | imm_ext_ex;
      ALU_LUI:  alu_out_ex = {imm_ext_ex[15:0], 16'd0};
      ALU_ADDI: alu_out_ex = alu_a_ex + imm_ext_ex;
      default:  alu_out_ex = 32'd0;
    endcase
    rega3_ex = dest_reg(instr_ex);
  end

  // Store data in MEM can only still be stale with respect to the WB write.
  always_comb begin
    fwd_rt_mem = FWD_MEM_PIPE;
    if (is_sw(instr_mem) && wb_write && f_rt(instr_mem) == rega3_wb)
      fwd_rt_mem = FWD_MEM_WD_WB;
  end

`ifdef CORE_TRACE_EN
  logic unused_instr_wb;
  assign unused_instr_wb = ^instr_wb;

  always @(posedge clk) begin
    if (!reset && wb_write)
      $display("%d@%h: $%d <= %h", $time, pc_wb, rega3_wb, wd_wb);
  end
`else
  logic unused_trace_inputs;
  assign unused_trace_inputs = ^{instr_wb, pc_wb};
`endif

endmodule

// File: tb/tb_decode_execute_core.sv
// Randomized + directed bench for decode_execute_core with a reference
// model, an expected-response queue and a negedge monitor.
module tb_decode_execute_core;

  logic        clk, reset;
  logic [31:0] instr_id, pc_id, instr_ex, instr_mem, instr_wb;
  logic [31:0] rs_data_ex, rt_data_ex, imm_ext_ex;
  logic [4:0]  rega3_mem, rega3_wb;
  logic [31:0] alu_out_mem, pc8_ex, pc8_mem, wd_wb, pc_wb;
  logic        rf_we_wb;
  logic [1:0]  npc_op, fwd_rt_mem;
  logic [31:0] npc_value, rs_data_id, rt_data_id, imm_ext_id;
  logic [31:0] alu_a_ex, alu_b_ex, alu_out_ex;
  logic [4:0]  rega3_ex;

  decode_execute_core dut (
    .clk(clk), .reset(reset), .instr_id(instr_id), .pc_id(pc_id),
    .instr_ex(instr_ex), .instr_mem(instr_mem), .instr_wb(instr_wb),
    .rs_data_ex(rs_data_ex), .rt_data_ex(rt_data_ex), .imm_ext_ex(imm_ext_ex),
    .rega3_mem(rega3_mem), .rega3_wb(rega3_wb), .alu_out_mem(alu_out_mem),
    .pc8_ex(pc8_ex), .pc8_mem(pc8_mem), .wd_wb(wd_wb), .rf_we_wb(rf_we_wb),
    .pc_wb(pc_wb), .npc_op(npc_op), .npc_value(npc_value),
    .rs_data_id(rs_data_id), .rt_data_id(rt_data_id), .imm_ext_id(imm_ext_id),
    .alu_a_ex(alu_a_ex), .alu_b_ex(alu_b_ex), .alu_out_ex(alu_out_ex),
    .rega3_ex(rega3_ex), .fwd_rt_mem(fwd_rt_mem)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  npc_op;
    logic [31:0] npc_value;
    logic [31:0] rs_id;
    logic [31:0] rt_id;
    logic [31:0] imm_id;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic [4:0]  rega3;
    logic [1:0]  fwd_rt_mem;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] grf_m [32];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic string kind(input logic [31:0] i);
    case (i[31:26])
      6'h00: begin
        if (i[5:0] == 6'h21) return "addu";
        if (i[5:0] == 6'h23) return "subu";
        if (i[5:0] == 6'h08) return "jr";
        return "nop";
      end
      6'h0d: return "ori";
      6'h0f: return "lui";
      6'h23: return "lw";
      6'h2b: return "sw";
      6'h04: return "beq";
      6'h02: return "j";
      6'h03: return "jal";
      default: return "nop";
    endcase
  endfunction

  function automatic logic [4:0] dest_of(input logic [31:0] i);
    string k = kind(i);
    if (k == "addu" || k == "subu") return i[15:11];
    if (k == "ori" || k == "lui" || k == "lw") return i[20:16];
    if (k == "jal") return 5'd31;
    return 5'd0;
  endfunction

  function automatic logic alu_producer(input logic [31:0] i);
    string k = kind(i);
    return k == "addu" || k == "subu" || k == "ori" || k == "lui";
  endfunction

  function automatic logic [31:0] grf_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (rf_we_wb && rega3_wb == a) return wd_wb;
    return grf_m[a];
  endfunction

  // Nearest producer first: EX (jal only), then MEM, else register file.
  function automatic logic [31:0] id_value(input logic [4:0] r);
    if (r != 5'd0 && kind(instr_ex) == "jal" && r == 5'd31) return pc8_ex;
    if (r != 5'd0 && r == rega3_mem && alu_producer(instr_mem)) return alu_out_mem;
    if (r != 5'd0 && r == rega3_mem && kind(instr_mem) == "jal") return pc8_mem;
    return grf_read(r);
  endfunction

  function automatic logic [31:0] ex_value(input logic [4:0] r, input logic [31:0] pipe);
    if (r == 5'd0) return pipe;
    if (r == rega3_mem && alu_producer(instr_mem)) return alu_out_mem;
    if (r == rega3_mem && kind(instr_mem) == "jal") return pc8_mem;
    if (rf_we_wb && r == rega3_wb) return wd_wb;
    return pipe;
  endfunction

  function automatic exp_t model();
    exp_t        e;
    string       k = kind(instr_id);
    string       kx = kind(instr_ex);
    logic [31:0] sx = {{16{instr_id[15]}}, instr_id[15:0]};
    e.rs_id  = grf_read(instr_id[25:21]);
    e.rt_id  = grf_read(instr_id[20:16]);
    e.imm_id = (k == "ori") ? {16'd0, instr_id[15:0]} : sx;
    e.npc_op = 2'd0;
    e.npc_value = pc_id + 32'd4;
    if (k == "beq" && id_value(instr_id[25:21]) == id_value(instr_id[20:16])) begin
      e.npc_op = 2'd1;
      e.npc_value = pc_id + 32'd4 + sx * 32'd4;
    end else if (k == "j" || k == "jal") begin
      e.npc_op = 2'd2;
      e.npc_value = {pc_id[31:28], instr_id[25:0], 2'b00};
    end else if (k == "jr") begin
      e.npc_op = 2'd3;
      e.npc_value = id_value(instr_id[25:21]);
    end
    e.alu_a = ex_value(instr_ex[25:21], rs_data_ex);
    e.alu_b = ex_value(instr_ex[20:16], rt_data_ex);
    if (kx == "addu") e.alu_out = e.alu_a + e.alu_b;
    else if (kx == "subu") e.alu_out = e.alu_a - e.alu_b;
    else if (kx == "ori") e.alu_out = e.alu_a | imm_ext_ex;
    else if (kx == "lui") e.alu_out = imm_ext_ex << 16;
    else if (kx == "lw" || kx == "sw") e.alu_out = e.alu_a + imm_ext_ex;
    else e.alu_out = 32'd0;
    e.rega3 = dest_of(instr_ex);
    e.fwd_rt_mem = (kind(instr_mem) == "sw" && instr_mem[20:16] != 5'd0 && rf_we_wb
                    && rega3_wb == instr_mem[20:16]) ? 2'd1 : 2'd0;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (v) for (int i = 0; i < 32; i++) grf_m[i] = 32'd0;
  endtask

  task automatic clear_inputs();
    instr_id = '0; pc_id = '0; instr_ex = '0; instr_mem = '0; instr_wb = '0;
    rs_data_ex = '0; rt_data_ex = '0; imm_ext_ex = '0; rega3_mem = '0;
    rega3_wb = '0; alu_out_mem = '0; pc8_ex = '0; pc8_mem = '0; wd_wb = '0;
    rf_we_wb = 1'b0; pc_wb = '0;
  endtask

  // The write seen by the model lands on the next rising edge.
  task automatic issue();
    exp_q.push_back(model());
    if (!reset && rf_we_wb && rega3_wb != 5'd0) grf_m[rega3_wb] = wd_wb;
  endtask

  function automatic logic [4:0] rnd_reg();
    logic [4:0] r = 5'($urandom_range(0, 7));
    return (r == 5'd7) ? 5'd31 : r;
  endfunction

  function automatic logic [31:0] rnd_val();
    return ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [15:0] imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0:  return rtype(rnd_reg(), rnd_reg(), rnd_reg(), 6'h21);
      1:  return rtype(rnd_reg(), rnd_reg(), rnd_reg(), 6'h23);
      2:  return itype(6'h0d, rnd_reg(), rnd_reg(), imm);
      3:  return itype(6'h0f, 5'd0, rnd_reg(), imm);
      4:  return itype(6'h23, rnd_reg(), rnd_reg(), imm);
      5:  return itype(6'h2b, rnd_reg(), rnd_reg(), imm);
      6:  return itype(6'h04, rnd_reg(), rnd_reg(), imm);
      7:  return jtype(6'h02, 26'($urandom));
      8:  return jtype(6'h03, 26'($urandom));
      9:  return rtype(rnd_reg(), 5'd0, 5'd0, 6'h08);
      10: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("npc_op", {30'd0, npc_op}, {30'd0, mon_e.npc_op});
      check("npc_value", npc_value, mon_e.npc_value);
      check("rs_data_id", rs_data_id, mon_e.rs_id);
      check("rt_data_id", rt_data_id, mon_e.rt_id);
      check("imm_ext_id", imm_ext_id, mon_e.imm_id);
      check("alu_a_ex", alu_a_ex, mon_e.alu_a);
      check("alu_b_ex", alu_b_ex, mon_e.alu_b);
      check("alu_out_ex", alu_out_ex, mon_e.alu_out);
      check("rega3_ex", {27'd0, rega3_ex}, {27'd0, mon_e.rega3});
      check("fwd_rt_mem", {30'd0, fwd_rt_mem}, {30'd0, mon_e.fwd_rt_mem});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    set_reset(1'b1);
    next_cycle(); issue();

    next_cycle(); set_reset(1'b0);
    rf_we_wb = 1'b1; rega3_wb = 5'd5; wd_wb = 32'h1234;
    instr_id = rtype(5'd5, 5'd0, 5'd0, 6'h21); issue();
    next_cycle(); rf_we_wb = 1'b0; issue();
    next_cycle(); rf_we_wb = 1'b1; rega3_wb = 5'd0; wd_wb = 32'hdead;
    instr_id = rtype(5'd0, 5'd5, 5'd0, 6'h21); issue();
    next_cycle(); rf_we_wb = 1'b0; issue();

    next_cycle(); clear_inputs();
    instr_ex = rtype(5'd1, 5'd2, 5'd3, 6'h21); rs_data_ex = 32'd7; rt_data_ex = 32'd5; issue();
    next_cycle(); instr_ex = rtype(5'd1, 5'd2, 5'd3, 6'h23);
    rs_data_ex = 32'd5; rt_data_ex = 32'd7; issue();
    next_cycle(); instr_ex = itype(6'h0d, 5'd1, 5'd2, 16'h000f);
    rs_data_ex = 32'hf0f0; imm_ext_ex = 32'h000f; issue();
    next_cycle(); instr_ex = itype(6'h0f, 5'd0, 5'd2, 16'h8000); imm_ext_ex = 32'hffff8000; issue();

    next_cycle(); clear_inputs();
    instr_mem = rtype(5'd1, 5'd2, 5'd4, 6'h21); rega3_mem = 5'd4; alu_out_mem = 32'haaaa0001;
    instr_ex = rtype(5'd4, 5'd0, 5'd5, 6'h21); rs_data_ex = 32'h11; issue();
    next_cycle(); instr_mem = '0; rega3_mem = '0;
    rf_we_wb = 1'b1; rega3_wb = 5'd4; wd_wb = 32'hbbbb; issue();
    next_cycle(); rf_we_wb = 1'b0; instr_mem = itype(6'h23, 5'd1, 5'd4, 16'd0);
    rega3_mem = 5'd4; issue();

    next_cycle(); clear_inputs(); rf_we_wb = 1'b1; rega3_wb = 5'd2; wd_wb = 32'h55; issue();
    next_cycle(); clear_inputs();
    instr_id = itype(6'h04, 5'd1, 5'd2, 16'hffff); pc_id = 32'h3000;
    instr_mem = rtype(5'd3, 5'd3, 5'd1, 6'h21); rega3_mem = 5'd1; alu_out_mem = 32'h55; issue();
    next_cycle(); clear_inputs();
    instr_ex = jtype(6'h03, 26'h100); pc8_ex = 32'h4008;
    instr_id = rtype(5'd31, 5'd0, 5'd0, 6'h08); issue();
    next_cycle(); clear_inputs(); instr_id = jtype(6'h02, 26'h0c00); pc_id = 32'h3004; issue();
    next_cycle(); clear_inputs(); instr_mem = itype(6'h2b, 5'd1, 5'd6, 16'd4);
    rf_we_wb = 1'b1; rega3_wb = 5'd6; wd_wb = 32'h66; issue();
    next_cycle(); rega3_wb = 5'd7; wd_wb = 32'h77; instr_id = rtype(5'd7, 5'd6, 5'd0, 6'h21); issue();

    next_cycle(); clear_inputs(); set_reset(1'b1); instr_id = rtype(5'd7, 5'd6, 5'd0, 6'h21); issue();
    next_cycle(); rf_we_wb = 1'b1; rega3_wb = 5'd7; wd_wb = 32'h99; issue();
    next_cycle(); set_reset(1'b0); rf_we_wb = 1'b0; issue();

    for (int n = 0; n < 500; n++) begin
      next_cycle();
      set_reset($urandom_range(0, 60) == 0);
      instr_id = rnd_instr(); instr_ex = rnd_instr(); instr_mem = rnd_instr(); instr_wb = $urandom;
      pc_id = $urandom & 32'hffff_fffc; pc_wb = $urandom;
      rs_data_ex = rnd_val(); rt_data_ex = rnd_val(); imm_ext_ex = $urandom;
      rega3_mem = ($urandom_range(0, 4) == 0) ? rnd_reg() : dest_of(instr_mem);
      rega3_wb = rnd_reg(); rf_we_wb = 1'($urandom_range(0, 1));
      alu_out_mem = rnd_val(); pc8_ex = rnd_val(); pc8_mem = rnd_val(); wd_wb = rnd_val();
      issue();
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_execute_core.md
# decode_execute_core

Combined decode, register-file, forwarding-control and execute block of the 5-stage MIPS pipeline (P5). It sits between the IF/ID and EX/MEM pipeline registers. It decodes the ID-stage instruction, reads and writes the 32×32 GRF, resolves branches and jumps in ID, and generates all forwarding selects for the ID, EX and MEM stages. It also computes the EX-stage ALU result and destination register. Pipeline registers, stall detection, IF, DM and the WB mux stay outside.

## Interface
Parameters: none.
- clk  in  1  pipeline clock; GRF writes on rising edge
- reset  in  1  asynchronous, active-high; clears GRF
- instr_id, pc_id  in  32  ID-stage instruction and its PC
- instr_ex, instr_mem, instr_wb  in  32  instructions in the later stages
- rs_data_ex, rt_data_ex, imm_ext_ex  in  32  ID/EX register contents
- rega3_mem, rega3_wb  in  5  destination registers of MEM/WB
- alu_out_mem, pc8_ex, pc8_mem, wd_wb  in  32  forwarding sources
- rf_we_wb  in  1  GRF write enable from WB
- pc_wb  in  32  WB-stage PC, used for trace only
- npc_op  out  2  00 sequential, 01 beq taken, 10 j/jal, 11 jr
- npc_value  out  32  next-PC target
- rs_data_id, rt_data_id, imm_ext_id  out  32  GRF reads with bypass, and extended immediate
- alu_a_ex, alu_b_ex  out  32  forwarded EX operands; alu_b_ex is also the store data sent to EX/MEM
- alu_out_ex  out  32  ALU result
- rega3_ex  out  5  EX destination register
- fwd_rt_mem  out  2  MEM store-data select: 0 pipe value, 1 wd_wb

## Operation
- ISA: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop (all-zero word). Any other encoding behaves as nop.
- GRF:
  - Register 0 is hardwired to 0.
  - Write occurs when rf_we_wb is high and rega3_wb is nonzero.
  - Reads are combinational with write-through: if a read address equals a nonzero rega3_wb and rf_we_wb is high, the read returns wd_wb.
- Immediate extension: zero-extend for ori; sign-extend for all other opcodes.
- ID forward mux select encoding: 0 GRF, 1 alu_out_mem, 2 pc8_mem, 3 pc8_ex. The muxes feed the branch compare and jr. rs_data_id and rt_data_id are the unforwarded GRF outputs.
- Branch and jump resolution:
  - beq taken when forwarded rs == rt → npc_op=01, npc_value = pc_id + 4 + (sext(imm) << 2).
  - j and jal → npc_op=10, npc_value = {pc_id[31:28], instr[25:0], 2'b00}.
  - jr → npc_op=11, npc_value = forwarded rs.
  - Otherwise npc_op=00 and npc_value = pc_id + 4.
- Destination register (for rega3_ex):
  - addu, subu → rd
  - ori, lui, lw → rt
  - jal → 31
  - anything else → 0
- ALU:
  - addu: A + B (wrapping)
  - subu: A − B
  - ori: A | imm
  - lui: {imm[15:0], 16'b0}
  - lw, sw: A + imm
  - others: 0
- EX forward select encoding: 0 pipe value, 1 wd_wb, 2 pc8_mem, 3 alu_out_mem.
- Forwarding rule: a match requires a nonzero source register equal to the producer's destination register.
  - EX producer: jal only, value pc8_ex.
  - MEM producer: ALU ops give alu_out_mem; jal gives pc8_mem; lw is never forwarded from MEM.
  - WB producer: any write, value wd_wb.
  - The nearest matching stage has priority.
  - ID consumers use EX and MEM producers. EX consumers use MEM and WB producers. MEM sw rt uses WB only.

## Timing
- All outputs are combinational except GRF contents. Latency is 0 cycles, plus a 1-cycle GRF write.
- Reset asserted mid-operation clears every GRF entry immediately. During reset, read data is 0 unless write-through applies.
- A write and a read of the same register in the same cycle return the new value.

## Configuration
- Macro CORE_TRACE_EN.
- Defined: on each rising clk with reset low and a GRF write occurring, `$display("%d@%h: $%d <= %h", $time, pc_wb, rega3_wb, wd_wb)`.
- Not defined: no simulation output. Logic is identical either way.

## Structure
- Shared package `mips_pkg`:
  - opcode/funct constants
  - npc_op codes
  - forward-select encodings
  - ALU-op enum
  - field-extraction functions (rs, rt, rd, imm, type predicates)
- Sub-module `grf` (32×32 register file with write-through). Decode, forwarding and ALU stay in the top module.

## Test plan
- Reset, then rf_we_wb=1, rega3_wb=5, wd_wb=0x1234, instr_id reading $5 in the same cycle → rs_data_id=0x1234. After the edge, the value persists. A write to $0 is ignored.
- instr_ex=addu $3,$1,$2 with rs=7, rt=5 → alu_out_ex=12, rega3_ex=3. subu 5−7 → 0xFFFFFFFE. ori 0xF0F0 | 0x000F → 0xF0FF. lui 0x8000 → 0x80000000.
- instr_mem=addu to $4, instr_ex consumer uses $4 as rs → forward select 3. The same dependency with the producer in WB only → select 1. instr_mem=lw $4 → select 0.
- beq $1,$2,-1 at pc_id=0x3000 with alu_out_mem forwarding equal values → npc_op=01, npc_value=0x3000.
- instr_ex=jal, instr_id=jr $31 → ID rs select 3, npc_op=11, npc_value=pc8_ex. j 0x0C00 at 0x3004 → npc_value=0x00003000.
- sw $6 in MEM with instr_wb writing $6 → fwd_rt_mem=1.
